// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the funct3 legality check used when a request is accepted.
package lsu_pkg;

  // Load encodings (RISC-V funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (RISC-V funct3)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // True when funct3 names an access this unit implements for the given direction.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic for the load/store unit: extracts and extends load data,
// merges sub-word store data into a memory word, and flags misaligned
// halfword/word addresses. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes out of the memory word.
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load type.
  always_comb begin
    load_val = '0;
    case (funct3)
      F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_val = word;
      F3_LBU:  load_val = {24'd0, byte_sel};
      F3_LHU:  load_val = {16'd0, half_sel};
      default: load_val = '0;
    endcase
  end

  // Replace the addressed lane of the old word with the low store-data bits.
  always_comb begin
    store_word = word;
    case (funct3)
      F3_SB: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          2'd3:    store_word[31:24] = wdata[7:0];
          default: store_word        = word;
        endcase
      end
      F3_SH: begin
        if (addr_lo[1]) begin
          store_word[31:16] = wdata[15:0];
        end else begin
          store_word[15:0] = wdata[15:0];
        end
      end
      F3_SW:   store_word = wdata;
      default: store_word = word;
    endcase
  end

  // Halfwords need an even address, words a multiple of four.
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator for the single-cycle core. Accepts one byte-addressed
// load/store at a time, reads the word (loads and sub-word stores), writes the
// merged word (stores), then reports completion with a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] align_word;
  logic [1:0]  align_addr;
  logic [2:0]  align_funct3;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic        misalign;
  logic        out_of_range;
  logic        req_err;
  logic        transfer;

  // Lane logic sees the incoming request while idle (for the misalign check),
  // the live memory word while reading, and the latched word otherwise.
  always_comb begin
    align_word   = (state_q == READ) ? mem_rd : word_q;
    align_addr   = addr_q[1:0];
    align_funct3 = funct3_q;
    if (state_q == IDLE) begin
      align_addr   = req_addr[1:0];
      align_funct3 = req_funct3;
    end
  end

  lsu_align u_align (
    .word       (align_word),
    .addr_lo    (align_addr),
    .funct3     (align_funct3),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word),
    .misalign   (misalign)
  );

  assign out_of_range = (req_addr[31:2] >> DEPTH_LOG2) != '0;
  assign req_err      = !funct3_legal(req_we, req_funct3) | misalign | out_of_range;
  assign transfer     = req_valid & req_ready;

  assign req_ready  = (state_q == IDLE) & !rst;
  assign resp_valid = (state_q == RESP) & !rst;
  assign resp_rdata = rst ? '0 : resp_rdata_q;
  assign resp_err   = resp_err_q & !rst;
  assign mem_we     = (state_q == WRITE) & !rst;
  assign mem_A      = rst ? '0 : {2'b00, addr_q[31:2]};
  assign mem_wd     = mem_we ? store_word : '0;

  // Next-state and register updates; the load result is extracted from the
  // word being captured into word_q so it is registered on entry to RESP.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          we_d     = req_we;
          wdata_d  = req_wdata;
          if (req_err) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_we && (req_funct3 == F3_SW)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        word_d = mem_rd;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_val;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      word_q       <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 16-word data memory, a byte-level reference
// model of every access, directed cases and a randomized access stream.
module tb_load_store_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] lastRdata;
  logic        lastErr;
  int          lastLat;
  int          lastNw;
  int          lastWk;
  logic [31:0] lastWA;
  logic [31:0] lastWD;

  load_store_unit #(.DEPTH_LOG2(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Combinational-read memory that returns zero while being written.
  assign mem_rd = mem_we ? 32'h0 : ((mem_A < 32'd16) ? mem[mem_A[3:0]] : 32'h0);

  // Synchronous memory write port, plus a preload path used during reset.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (mem_we && (mem_A < 32'd16)) begin
      mem[mem_A[3:0]] <= mem_wd;
    end
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference behaviour in byte terms: legality, alignment, range, lane
  // arithmetic and latency, updating the shadow memory for stores.
  task automatic refAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                           output int lat, output int nwrites, output logic [31:0] widx,
                           output logic [31:0] wword);
    int          nbytes;
    int          off;
    logic [31:0] idx;
    logic [31:0] mask;
    logic        legal;
    nbytes = 1 << int'(f3[1:0]);
    off    = int'(addr % 4);
    idx    = addr >> 2;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    err     = !legal || ((addr % nbytes) != 0) || (idx >= DEPTH);
    rdata   = 32'h0;
    nwrites = 0;
    widx    = 32'h0;
    wword   = 32'h0;
    mask    = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (err) begin
      lat = 1;
    end else if (!we) begin
      rdata = (ref_mem[idx[3:0]] >> (8 * off)) & mask;
      if (!f3[2] && (nbytes < 4) && rdata[8 * nbytes - 1]) rdata = rdata | ~mask;
      lat = 2;
    end else begin
      wword = (ref_mem[idx[3:0]] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      ref_mem[idx[3:0]] = wword;
      widx    = idx;
      nwrites = 1;
      lat     = (nbytes == 4) ? 2 : 3;
    end
  endtask

  // Issue one request, watch the memory port and response, compare to the model.
  task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        eErr;
    logic [31:0] eRd, eIdx, eWd;
    int          eLat, eNw;
    int          w;
    refAccess(we, f3, addr, wdata, eErr, eRd, eLat, eNw, eIdx, eWd);
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    w = 0;
    while (!req_ready && (w < 10)) begin
      @(negedge clk);
      w++;
    end
    checkOutput({name, "/accepted"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lastLat = 0;
    lastNw  = 0;
    lastWk  = 0;
    lastWA  = 32'h0;
    lastWD  = 32'h0;
    lastRdata = 32'h0;
    lastErr   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_we) begin
        lastNw++;
        lastWk = k;
        lastWA = mem_A;
        lastWD = mem_wd;
      end
      if (resp_valid) begin
        lastLat   = k;
        lastRdata = resp_rdata;
        lastErr   = resp_err;
        break;
      end
      @(negedge clk);
    end
    checkOutput({name, "/latency"}, 32'(lastLat), 32'(eLat));
    checkOutput({name, "/err"}, 32'(lastErr), 32'(eErr));
    checkOutput({name, "/rdata"}, lastRdata, eRd);
    checkOutput({name, "/writes"}, 32'(lastNw), 32'(eNw));
    if (eNw != 0) begin
      checkOutput({name, "/write_cycle"}, 32'(lastWk), 32'(eLat - 1));
      checkOutput({name, "/mem_A"}, lastWA, eIdx);
      checkOutput({name, "/mem_wd"}, lastWD, eWd);
    end
    @(negedge clk);
    checkOutput({name, "/pulse_end"}, 32'(resp_valid), 32'd0);
    checkOutput({name, "/rdata_cleared"}, {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'd0);
    checkOutput({name, "/idle_ready"}, 32'(req_ready), 32'd1);
    if (eNw != 0) checkOutput({name, "/mem_word"}, mem[eIdx[3:0]], eWd);
  endtask

  initial begin
    logic [31:0] v;
    logic        rWe;
    logic [2:0]  rF3;
    logic [31:0] rIdx;
    logic [31:0] rAddr;
    int          r;
    int          acc, r1, r2, wcount, wk;
    logic        e1;
    logic [31:0] rd2, wA, wD;
    logic        dErr;
    logic [31:0] dRd, dIdx, dWd;
    int          dLat, dNw;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pl_en      = 1'b0;
    pl_idx     = 4'd0;
    pl_val     = 32'h0;

    // Preload memory while reset is held.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v = (i == 5) ? 32'h8899_AABB : $urandom;
      pl_en  = 1'b1;
      pl_idx = 4'(i);
      pl_val = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    pl_en = 1'b0;

    checkOutput("reset/req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset/resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset/resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset/resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset/mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset/mem_A", mem_A, 32'd0);
    checkOutput("reset/mem_wd", mem_wd, 32'd0);
    rst = 1'b0;

    // Loads from the preloaded word 0x8899AABB at index 5.
    applyStimulus("lb16", 1'b0, 3'b000, 32'h16, 32'h0);
    checkOutput("lb16/value", lastRdata, 32'hFFFF_FF99);
    applyStimulus("lbu16", 1'b0, 3'b100, 32'h16, 32'h0);
    checkOutput("lbu16/value", lastRdata, 32'h0000_0099);
    applyStimulus("lh14", 1'b0, 3'b001, 32'h14, 32'h0);
    checkOutput("lh14/value", lastRdata, 32'hFFFF_AABB);
    applyStimulus("lhu16", 1'b0, 3'b101, 32'h16, 32'h0);
    checkOutput("lhu16/value", lastRdata, 32'h0000_8899);

    // Byte store as read-modify-write.
    applyStimulus("sb15", 1'b1, 3'b000, 32'h15, 32'h1234_56CC);
    checkOutput("sb15/one_write", 32'(lastNw), 32'd1);
    checkOutput("sb15/write_at", 32'(lastWk), 32'd2);
    checkOutput("sb15/index", lastWA, 32'd5);
    checkOutput("sb15/word", lastWD, 32'h8899_CCBB);
    checkOutput("sb15/resp_at", 32'(lastLat), 32'd3);

    // Rejected accesses: misaligned word store, out-of-range word load.
    applyStimulus("sw2", 1'b1, 3'b010, 32'h2, 32'h5555_5555);
    checkOutput("sw2/err", 32'(lastErr), 32'd1);
    checkOutput("sw2/no_write", 32'(lastNw), 32'd0);
    checkOutput("sw2/resp_at", 32'(lastLat), 32'd1);
    applyStimulus("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0);
    checkOutput("lw1000/err", 32'(lastErr), 32'd1);
    checkOutput("lw1000/no_write", 32'(lastNw), 32'd0);
    checkOutput("lw1000/resp_at", 32'(lastLat), 32'd1);

    // Reset raised during the write cycle of a halfword store.
    @(negedge clk);
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h0A;
    req_wdata  = 32'h0000_BEEF;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstmid/read_no_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid/write_gated", 32'(mem_we), 32'd0);
    checkOutput("rstmid/no_resp", 32'(resp_valid), 32'd0);
    checkOutput("rstmid/not_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("rstmid/held_ready", 32'(req_ready), 32'd0);
    checkOutput("rstmid/held_mem_A", mem_A, 32'd0);
    checkOutput("rstmid/held_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid/ready_after", 32'(req_ready), 32'd1);
    checkOutput("rstmid/no_resp_after", 32'(resp_valid), 32'd0);
    checkOutput("rstmid/mem2_kept", mem[2], ref_mem[2]);

    // Back-to-back with req_valid held: SW 0x0 then LW 0x0.
    refAccess(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, dErr, dRd, dLat, dNw, dIdx, dWd);
    refAccess(1'b0, 3'b010, 32'h0, 32'h0, dErr, dRd, dLat, dNw, dIdx, dWd);
    @(negedge clk);
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'hDEAD_BEEF;
    req_valid  = 1'b1;
    checkOutput("b2b/first_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_we     = 1'b0;
    req_wdata  = 32'h0;
    acc = 0; r1 = 0; r2 = 0; wcount = 0; wk = 0;
    e1 = 1'b1; rd2 = 32'h0; wA = 32'h0; wD = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      if (req_ready && (acc == 0)) acc = k;
      if (mem_we) begin
        wcount++;
        wk = k;
        wA = mem_A;
        wD = mem_wd;
      end
      if (resp_valid) begin
        if (r1 == 0) begin
          r1 = k;
          e1 = resp_err;
        end else begin
          r2  = k;
          rd2 = resp_rdata;
        end
      end
      if ((acc != 0) && (k == acc + 1)) req_valid = 1'b0;
      if (r2 != 0) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("b2b/second_accept", 32'(acc), 32'd3);
    checkOutput("b2b/sw_resp_at", 32'(r1), 32'd2);
    checkOutput("b2b/sw_err", 32'(e1), 32'd0);
    checkOutput("b2b/sw_writes", 32'(wcount), 32'd1);
    checkOutput("b2b/sw_write_at", 32'(wk), 32'd1);
    checkOutput("b2b/sw_mem_A", wA, 32'd0);
    checkOutput("b2b/sw_mem_wd", wD, 32'hDEAD_BEEF);
    checkOutput("b2b/lw_resp_at", 32'(r2), 32'd5);
    checkOutput("b2b/lw_rdata", rd2, 32'hDEAD_BEEF);
    checkOutput("b2b/lw_model", rd2, dRd);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      rWe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (rWe) begin
          rF3 = 3'($urandom_range(0, 2));
        end else begin
          r   = int'($urandom_range(0, 4));
          rF3 = (r < 3) ? 3'(r) : 3'(r + 1);
        end
      end else begin
        rF3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) rIdx = 32'($urandom_range(1024, 5000));
      else                           rIdx = 32'($urandom_range(0, 15));
      rAddr = (rIdx << 2) | 32'($urandom_range(0, 3));
      applyStimulus($sformatf("rnd%0d", i), rWe, rF3, rAddr, $urandom);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
